biased_demux: RTL and testbench

- Two-output packet stream demultiplexer: the receive-side counterpart of the two-input packet mux.
- Routes one continuous input stream to output 0 or output 1, or discards it. The routing choice is made per packet.
- The route is taken from dest_in/drop_in on the first beat of a packet and held until last is handshaked.
- A registered skid stage breaks every ready path. Per-destination packet counters feed the status registers.

---
 rtl/biased_demux_pkg.sv | 17 +
 rtl/biased_demux_if.sv | 21 ++
 rtl/biased_demux_skid_buffer.sv | 56 +++++
 rtl/biased_demux.sv | 128 ++++++++++++
 tb/tb_biased_demux.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biased_demux_pkg.sv
// Shared types and constants for the packet-stream demux library.
//   demux_beat_t : one buffered beat {data, last, dest} at the default 32-bit width
//   DEST_0/DEST_1: destination encodings carried in the beat's dest field
package stream_pkg;

  localparam int unsigned P_DEMUX_DATA_WIDTH = 32;

  localparam logic DEST_0 = 1'b0;
  localparam logic DEST_1 = 1'b1;

  typedef struct packed {
    logic [P_DEMUX_DATA_WIDTH-1:0] data;
    logic                          last;
    logic                          dest;
  } demux_beat_t;

endpackage

// File: rtl/biased_demux_if.sv
// Valid/ready packet stream bundle.
//   valid/ready : beat handshake
//   last        : final beat of packet
//   data        : beat payload
//   dest/drop   : routing sideband (meaningful on the demux input only)
// master drives the stream, slave receives it and drives ready.
interface biased_demux_if #(
  parameter int unsigned P_DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic                    last;
  logic [P_DATA_WIDTH-1:0] data;
  logic                    dest;
  logic                    drop;

  modport master (output valid, last, data, dest, drop, input ready);
  modport slave  (input valid, last, data, dest, drop, output ready);

endinterface

// File: rtl/biased_demux_skid_buffer.sv
// stream_skid_buffer: generic 2-entry register slice (main + skid).
//   clk, rst   : clock, synchronous active-high reset (empties both entries)
//   push       : write push_beat this cycle; caller must not push while skid_valid
//   push_beat  : entry to store
//   pop        : main entry consumed this cycle (ignored when main is empty)
//   main_valid : head entry present
//   main_beat  : head entry
//   skid_valid : second entry occupied; callers derive their ready from !skid_valid
module stream_skid_buffer
  import stream_pkg::*;
#(
  parameter type T = demux_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_beat,
  input  logic pop,
  output logic main_valid,
  output T     main_beat,
  output logic skid_valid
);

  T     skid_beat;
  logic main_free;

  // main can be (re)loaded when empty or being drained this cycle
  assign main_free = !main_valid || pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= push;
      end else begin
        main_valid <= push;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
    end
  end

  // payload registers carry no reset; occupancy is tracked by the valid flags
  always_ff @(posedge clk) begin
    if (main_free) begin
      main_beat <= skid_valid ? skid_beat : push_beat;
    end
    if (push && (!main_free || skid_valid)) begin
      skid_beat <= push_beat;
    end
  end

endmodule

// File: rtl/biased_demux.sv
// biased_demux: routes one packet stream to output 0, output 1, or discards it.
// The route is sampled from up.dest/up.drop on the first beat of a packet and
// held until the last beat is accepted. A 2-entry skid stage registers ready.
//   clk, rst      : clock, synchronous active-high reset
//   up            : input stream (slave); dest/drop are the routing sideband
//   down_0/down_1 : output streams (master); dest/drop outputs are constant
//   busy          : mid-packet or buffer non-empty
//   pkt_count_0/1 : packets fully delivered per output (wrapping)
//   drop_count    : packets discarded (wrapping)
module biased_demux
  import stream_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  biased_demux_if.slave          up,
  biased_demux_if.master         down_0,
  biased_demux_if.master         down_1,
  output logic                   busy,
  output logic [P_CNT_WIDTH-1:0] pkt_count_0,
  output logic [P_CNT_WIDTH-1:0] pkt_count_1,
  output logic [P_CNT_WIDTH-1:0] drop_count
);

  typedef struct packed {
    logic [P_DATA_WIDTH-1:0] data;
    logic                    last;
    logic                    dest;
  } beat_t;

  logic  run;
  logic  in_pkt;
  logic  route_dest;
  logic  route_drop;
  logic  eff_dest;
  logic  eff_drop;
  logic  accept;
  logic  push;
  beat_t push_beat;
  logic  pop;
  logic  main_valid;
  beat_t main_beat;
  logic  skid_valid;
  logic  done_0;
  logic  done_1;

  // run holds ready low while rst is asserted and releases it one cycle later
  assign up.ready = run && !skid_valid;
  assign accept   = up.valid && up.ready;

  assign eff_dest = in_pkt ? route_dest : up.dest;
  assign eff_drop = in_pkt ? route_drop : up.drop;

  assign push      = accept && !eff_drop;
  assign push_beat = '{data: up.data, last: up.last, dest: eff_dest};

  always_ff @(posedge clk) begin
    if (rst) begin
      run        <= 1'b0;
      in_pkt     <= 1'b0;
      route_dest <= DEST_0;
      route_drop <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        in_pkt <= !up.last;
        if (!in_pkt) begin
          route_dest <= up.dest;
          route_drop <= up.drop;
        end
      end
    end
  end

  // head-of-line: the main entry waits only on the output it is addressed to
  assign pop = main_valid && ((main_beat.dest == DEST_1) ? down_1.ready : down_0.ready);

  stream_skid_buffer #(
    .T (beat_t)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_beat  (push_beat),
    .pop        (pop),
    .main_valid (main_valid),
    .main_beat  (main_beat),
    .skid_valid (skid_valid)
  );

  assign down_0.valid = main_valid && (main_beat.dest == DEST_0);
  assign down_0.last  = main_beat.last;
  assign down_0.data  = main_beat.data;
  assign down_0.dest  = DEST_0;
  assign down_0.drop  = 1'b0;

  assign down_1.valid = main_valid && (main_beat.dest == DEST_1);
  assign down_1.last  = main_beat.last;
  assign down_1.data  = main_beat.data;
  assign down_1.dest  = DEST_1;
  assign down_1.drop  = 1'b0;

  assign done_0 = down_0.valid && down_0.ready && down_0.last;
  assign done_1 = down_1.valid && down_1.ready && down_1.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_0 <= '0;
      pkt_count_1 <= '0;
      drop_count  <= '0;
    end else begin
      if (done_0) begin
        pkt_count_0 <= pkt_count_0 + 1'b1;
      end
      if (done_1) begin
        pkt_count_1 <= pkt_count_1 + 1'b1;
      end
      if (accept && up.last && eff_drop) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign busy = in_pkt || main_valid || skid_valid;

endmodule

// File: tb/tb_biased_demux.sv
module tb_biased_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v_in = 1'b0;
  logic        l_in = 1'b0;
  logic [31:0] d_in = '0;
  logic        dest_in = 1'b0;
  logic        drop_in = 1'b0;
  logic        r0 = 1'b1;
  logic        r1 = 1'b1;

  biased_demux_if #(.P_DATA_WIDTH(32)) up ();
  biased_demux_if #(.P_DATA_WIDTH(32)) dn0 ();
  biased_demux_if #(.P_DATA_WIDTH(32)) dn1 ();
  biased_demux_if #(.P_DATA_WIDTH(32)) up_s ();
  biased_demux_if #(.P_DATA_WIDTH(32)) dn0_s ();
  biased_demux_if #(.P_DATA_WIDTH(32)) dn1_s ();

  assign up.valid   = v_in;
  assign up.last    = l_in;
  assign up.data    = d_in;
  assign up.dest    = dest_in;
  assign up.drop    = drop_in;
  assign up_s.valid = v_in;
  assign up_s.last  = l_in;
  assign up_s.data  = d_in;
  assign up_s.dest  = dest_in;
  assign up_s.drop  = drop_in;
  assign dn0.ready   = r0;
  assign dn1.ready   = r1;
  assign dn0_s.ready = r0;
  assign dn1_s.ready = r1;

  logic        busy, busy_s;
  logic [15:0] pc0, pc1, dc;
  logic [1:0]  pc0_s, pc1_s, dc_s;

  biased_demux #(.P_DATA_WIDTH(32), .P_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .up(up), .down_0(dn0), .down_1(dn1),
    .busy(busy), .pkt_count_0(pc0), .pkt_count_1(pc1), .drop_count(dc)
  );

  biased_demux #(.P_DATA_WIDTH(32), .P_CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .up(up_s), .down_0(dn0_s), .down_1(dn1_s),
    .busy(busy_s), .pkt_count_0(pc0_s), .pkt_count_1(pc1_s), .drop_count(dc_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model: per-output expected beat queues ----------
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   exp_pk[2];
  int   exp_drop;

  logic        lat_en = 1'b0;
  logic        lat_pend = 1'b0;
  logic        lat_dest;
  logic [31:0] lat_data;
  logic        rand_rdy = 1'b0;
  logic [31:0] first_dat;

  logic        st_p[2];
  logic [32:0] st_word[2];

  task automatic check_port(input int d, input logic v, input logic r, input logic lst,
                            input logic [31:0] dat);
    exp_t e;
    if (st_p[d]) chk($sformatf("out%0d_stable", d), {v, lst, dat}, {1'b1, st_word[d]});
    if (lat_pend && (int'(lat_dest) == d))
      chk($sformatf("out%0d_latency", d), {v, dat}, {1'b1, lat_data});
    if (v && r) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        fail($sformatf("out%0d_unexpected", d), $sformatf("got beat %0h with nothing expected", dat));
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out%0d_beat", d), {lst, dat}, e);
        if (e.last) exp_pk[d]++;
      end
    end
    st_p[d]    = v && !r;
    st_word[d] = {lst, dat};
  endtask

  always @(negedge clk) begin
    if (rst) begin
      st_p[0]  = 1'b0;
      st_p[1]  = 1'b0;
      lat_pend = 1'b0;
    end else begin
      if (dn0.valid && dn1.valid) fail("both_valid", "valid on both outputs at once");
      check_port(0, dn0.valid, r0, dn0.last, dn0.data);
      check_port(1, dn1.valid, r1, dn1.last, dn1.data);
      lat_pend = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ---------------------------------------------------
  // Drives one packet, holding valid continuously until last is accepted.
  // Returns #1 after the edge that accepted the final (or abort_after-th) beat.
  task automatic send_pkt(input int len, input logic dest, input logic drop, input logic toggle,
                          input int abort_after, output int stalls);
    int          i;
    logic        acc;
    logic [31:0] dat;
    exp_t        e;
    i      = 0;
    stalls = 0;
    dat    = $urandom;
    first_dat = dat;
    v_in    = 1'b1;
    d_in    = dat;
    l_in    = (len == 1);
    dest_in = dest;
    drop_in = drop;
    while (i < len) begin
      @(negedge clk);
      acc = up.ready;
      @(posedge clk);
      if (acc) begin
        if (!drop) begin
          e = '{last: (i == len - 1), data: dat};
          if (dest) q1.push_back(e);
          else q0.push_back(e);
          if (lat_en) begin
            lat_pend = 1'b1;
            lat_dest = dest;
            lat_data = dat;
          end
        end else if (i == len - 1) begin
          exp_drop++;
        end
        i++;
        dat = $urandom;
      end else begin
        stalls++;
        if (stalls > 200) begin
          fail("send_timeout", "input never accepted");
          #1;
          break;
        end
      end
      #1;
      if (i == len || i == abort_after) break;
      if (i > 0) begin
        d_in    = dat;
        l_in    = (i == len - 1);
        dest_in = toggle ? ~dest_in : 1'($urandom);
        drop_in = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    v_in    = 1'b0;
    l_in    = 1'b0;
    dest_in = 1'($urandom);
    drop_in = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pkt_count_0"}, pc0, 16'(exp_pk[0]));
    chk({tag, "_pkt_count_1"}, pc1, 16'(exp_pk[1]));
    chk({tag, "_drop_count"}, dc, 16'(exp_drop));
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    rand_rdy = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    idle(0);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail({tag, "_drain"}, $sformatf("%0d/%0d beats never delivered", q0.size(), q1.size()));
    @(negedge clk);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    check_counts(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v_in = 1'b0;
    q0.delete();
    q1.delete();
    exp_pk[0] = 0;
    exp_pk[1] = 0;
    exp_drop  = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", up.ready, 1'b0);
    chk("rst_valid", {dn0.valid, dn1.valid}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_counts", {pc0, pc1, dc}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", up.ready, 1'b1);
  endtask

  typedef struct {
    int   len;
    logic dest;
    logic drop;
    logic toggle;
    int   exp_p0;
    int   exp_p1;
    int   exp_d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s1, s2, s3, st;
    tbl[0] = '{len: 3, dest: 1'b1, drop: 1'b0, toggle: 1'b1, exp_p0: 0, exp_p1: 1, exp_d: 0};
    tbl[1] = '{len: 5, dest: 1'b0, drop: 1'b0, toggle: 1'b1, exp_p0: 1, exp_p1: 1, exp_d: 0};
    tbl[2] = '{len: 3, dest: 1'b0, drop: 1'b1, toggle: 1'b0, exp_p0: 1, exp_p1: 1, exp_d: 1};
    tbl[3] = '{len: 1, dest: 1'b1, drop: 1'b0, toggle: 1'b0, exp_p0: 1, exp_p1: 2, exp_d: 1};
    tbl[4] = '{len: 1, dest: 1'b0, drop: 1'b1, toggle: 1'b0, exp_p0: 1, exp_p1: 2, exp_d: 2};
    tbl[5] = '{len: 2, dest: 1'b1, drop: 1'b1, toggle: 1'b1, exp_p0: 1, exp_p1: 2, exp_d: 3};

    // back-to-back packets 0,1,0 with both outputs ready
    do_reset();
    lat_en = 1'b1;
    send_pkt(4, 1'b0, 1'b0, 1'b0, 0, s1);
    send_pkt(4, 1'b1, 1'b0, 1'b0, 0, s2);
    send_pkt(4, 1'b0, 1'b0, 1'b0, 0, s3);
    idle(0);
    chk("t1_input_bubbles", s1 + s2 + s3, 0);
    drain("t1");
    chk("t1_pkt_count_0_two", pc0, 16'd2);
    chk("t1_pkt_count_1_one", pc1, 16'd1);

    // table: toggled dest mid-packet, drops, single-beat packets
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_pkt(tbl[i].len, tbl[i].dest, tbl[i].drop, tbl[i].toggle, 0, st);
      idle(1);
      drain($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_counts", i), {pc0, pc1, dc},
          {16'(tbl[i].exp_p0), 16'(tbl[i].exp_p1), 16'(tbl[i].exp_d)});
    end
    lat_en = 1'b0;

    // output 1 stalled for 5 cycles at the start of a packet
    r1 = 1'b0;
    fork
      send_pkt(6, 1'b1, 1'b0, 1'b0, 0, st);
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stall_ready_low", up.ready, 1'b0);
        chk("stall_head", {dn0.valid, dn1.valid, dn1.data}, {2'b01, first_dat});
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stall_ready_held", up.ready, 1'b0);
        chk("stall_head_held", {dn1.valid, dn1.data}, {1'b1, first_dat});
        @(posedge clk);
        #1;
        r1 = 1'b1;
      end
    join
    idle(1);
    drain("t4");

    // reset in the middle of a packet to output 0, then a packet to output 1
    lat_en = 1'b1;
    send_pkt(6, 1'b0, 1'b0, 1'b0, 2, st);
    do_reset();
    send_pkt(3, 1'b1, 1'b0, 1'b0, 0, st);
    idle(1);
    drain("t5");
    chk("t5_new_route", pc1, 16'd1);
    lat_en = 1'b0;

    // randomized traffic with random output backpressure
    do_reset();
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(1, 6), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 0, st);
      idle($urandom_range(0, 2));
    end
    drain("rand");

    // counter wrap on the narrow-counter instance
    do_reset();
    for (int p = 0; p < 5; p++) begin
      send_pkt(2, 1'b0, 1'b0, 1'b0, 0, st);
      idle(1);
    end
    drain("t6");
    chk("t6_wide_count", pc0, 16'd5);
    chk("t6_wrap_count", pc0_s, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
